// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: channel layout, stall counter
// width, occupancy states and small helpers.
package pipe_pkg;

  localparam int PIPE_CH_W   = 16;
  localparam int CH_RD1      = 0;
  localparam int CH_RD2      = 1;
  localparam int CH_IMM      = 2;
  localparam int CH_PC       = 3;
  localparam int STALL_CNT_W = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  // Occupancy is fully encoded by the two valid bits; skid is only ever valid behind main.
  function automatic pipe_state_e pipe_state(input logic main_v, input logic skid_v);
    if (skid_v) begin
      return ST_FULL;
    end else if (main_v) begin
      return ST_ONE;
    end
    return ST_EMPTY;
  endfunction

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: a valid bit plus a data register that only clocks in new data
// when set, so a stalled entry never toggles its data flops.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int W = 4 * PIPE_CH_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         set_i,
  input  logic         clr_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (set_i) begin
      valid_q <= 1'b1;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end
  end

  // Clear only drops the valid bit; the stale data is left in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (set_i) begin
      data_q <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with flush and optional skid entry (registered in_ready).
// Optional stall counter output enabled by defining PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = PIPE_CH_W,
  parameter int SKID   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_CH*CH_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_CH*CH_W-1:0] out_data
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  localparam int DW = NUM_CH * CH_W;

  logic          main_v;
  logic          skid_v;
  logic [DW-1:0] main_data;
  logic [DW-1:0] skid_data;
  logic [DW-1:0] main_d;
  logic          main_set;
  logic          main_from_skid;
  logic          main_clr;
  logic          skid_set;
  logic          skid_clr;
  logic          accept;
  logic          out_xfer;
  pipe_state_e   state;

  assign state    = pipe_state(main_v, skid_v);
  assign accept   = in_valid && in_ready;
  assign out_xfer = main_v && out_ready;
  assign main_d   = main_from_skid ? skid_data : in_data;

  always_comb begin
    main_set       = 1'b0;
    main_from_skid = 1'b0;
    main_clr       = 1'b0;
    skid_set       = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      // Squash everything held; an offered beat is dropped, an out transfer still counts.
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          main_set = accept;
        end
        ST_ONE: begin
          if (accept && out_xfer) begin
            main_set = 1'b1;
          end else if (accept) begin
            skid_set = 1'b1;
          end else if (out_xfer) begin
            main_clr = 1'b1;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            main_set       = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: begin
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  pipe_slot #(
    .W (DW)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .set_i   (main_set),
    .clr_i   (main_clr),
    .data_i  (main_d),
    .valid_o (main_v),
    .data_o  (main_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_slot #(
        .W (DW)
      ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .set_i   (skid_set),
        .clr_i   (skid_clr),
        .data_i  (in_data),
        .valid_o (skid_v),
        .data_o  (skid_data)
      );
      assign in_ready = !skid_v;
    end else begin : g_noskid
      // Without a skid entry ready must look through to the downstream consumer.
      logic unused_skid;
      assign unused_skid = skid_set ^ skid_clr;
      assign skid_v      = 1'b0;
      assign skid_data   = '0;
      assign in_ready    = !main_v || out_ready;
    end
  endgenerate

  assign out_valid = main_v;
  assign out_data  = main_data;

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic [STALL_CNT_W-1:0] stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_v && !out_ready) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end
  end

  // Flush deliberately leaves the count alone; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance driven with
// directed beats; stall counter checks appear when PIPE_STAGE_STALL_CNT_EN is defined.
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst;
  logic        flush1, in_valid1, in_ready1, out_valid1, out_ready1;
  logic [63:0] in_data1, out_data1;
  logic        flush0, in_valid0, in_ready0, out_valid0, out_ready0;
  logic [63:0] in_data0, out_data0;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [31:0] stall_cnt1, stall_cnt0;
`endif

  int errors = 0;
  int checks = 0;
  logic [63:0] q1[$];
  logic [63:0] q0[$];

  pipe_stage_reg #(.NUM_CH(4), .CH_W(16), .SKID(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1)
`ifdef PIPE_STAGE_STALL_CNT_EN
    , .stall_cnt(stall_cnt1)
`endif
  );

  pipe_stage_reg #(.NUM_CH(4), .CH_W(16), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0)
`ifdef PIPE_STAGE_STALL_CNT_EN
    , .stall_cnt(stall_cnt0)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rep(input logic [15:0] h);
    return {4{h}};
  endfunction

  // Monitors: every output transfer must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid1 === 1'b1 && out_ready1 === 1'b1) begin
      if (q1.size() == 0) begin
        chk("skid1_unexpected_beat", out_data1, 64'hx);
      end else begin
        chk("skid1_beat", out_data1, q1.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid0 === 1'b1 && out_ready0 === 1'b1) begin
      if (q0.size() == 0) begin
        chk("skid0_unexpected_beat", out_data0, 64'hx);
      end else begin
        chk("skid0_beat", out_data0, q0.pop_front());
      end
    end
  end

  logic [15:0] stream_v[4];

  initial begin
    stream_v = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    rst = 1'b1;
    flush1 = 1'b0; in_valid1 = 1'b1; in_data1 = '1; out_ready1 = 1'b0;
    flush0 = 1'b0; in_valid0 = 1'b1; in_data0 = '1; out_ready0 = 1'b0;
    tick();
    tick();
    rst = 1'b0; in_valid1 = 1'b0; in_valid0 = 1'b0;
    chk("rst_out_valid1", {63'd0, out_valid1}, 64'd0);
    chk("rst_out_data1", out_data1, 64'd0);
    chk("rst_in_ready1", {63'd0, in_ready1}, 64'd1);
    chk("rst_out_valid0", {63'd0, out_valid0}, 64'd0);
    chk("rst_out_data0", out_data0, 64'd0);
    chk("rst_in_ready0", {63'd0, in_ready0}, 64'd1);

    // Streaming at full rate.
    out_ready1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid1 = 1'b1;
      in_data1 = rep(stream_v[i]);
      chk("stream_in_ready", {63'd0, in_ready1}, 64'd1);
      q1.push_back(rep(stream_v[i]));
      tick();
      chk("stream_latency", out_data1, rep(stream_v[i]));
    end
    in_valid1 = 1'b0;
    tick();
    chk("stream_drained", {63'd0, out_valid1}, 64'd0);

    // Back-pressure fills main then skid; C must wait.
    out_ready1 = 1'b0;
    in_valid1 = 1'b1; in_data1 = rep(16'hAAAA); q1.push_back(rep(16'hAAAA));
    tick();
    chk("bp_ready_after_A", {63'd0, in_ready1}, 64'd1);
    in_data1 = rep(16'hBBBB); q1.push_back(rep(16'hBBBB));
    tick();
    chk("bp_ready_full", {63'd0, in_ready1}, 64'd0);
    in_data1 = rep(16'hCCCC);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_A", out_data1, rep(16'hAAAA));
      chk("bp_hold_ready", {63'd0, in_ready1}, 64'd0);
    end
    out_ready1 = 1'b1;
    q1.push_back(rep(16'hCCCC));
    tick();
    chk("bp_out_B", out_data1, rep(16'hBBBB));
    chk("bp_ready_reopen", {63'd0, in_ready1}, 64'd1);
    tick();
    in_valid1 = 1'b0;
    chk("bp_out_C", out_data1, rep(16'hCCCC));
    tick();
    chk("bp_empty", {63'd0, out_valid1}, 64'd0);

    // Flush while FULL: A leaves, B and D vanish.
    out_ready1 = 1'b0;
    in_valid1 = 1'b1; in_data1 = rep(16'hAAAA); q1.push_back(rep(16'hAAAA));
    tick();
    in_data1 = rep(16'hBBBB);
    tick();
    flush1 = 1'b1; in_data1 = rep(16'hDDDD); out_ready1 = 1'b1;
    tick();
    flush1 = 1'b0; in_valid1 = 1'b0;
    chk("flush_valid", {63'd0, out_valid1}, 64'd0);
    chk("flush_data_hold", out_data1, rep(16'hAAAA));
    chk("flush_ready", {63'd0, in_ready1}, 64'd1);
    tick();
    chk("flush_still_empty", {63'd0, out_valid1}, 64'd0);

    // SKID=0: ready follows out_ready combinationally.
    in_valid0 = 1'b1; in_data0 = rep(16'h5A5A); q0.push_back(rep(16'h5A5A));
    tick();
    in_data0 = rep(16'hC3C3);
    chk("comb_ready_blocked", {63'd0, in_ready0}, 64'd0);
    tick();
    chk("comb_hold_old", out_data0, rep(16'h5A5A));
    out_ready0 = 1'b1;
    #1;
    chk("comb_ready_open", {63'd0, in_ready0}, 64'd1);
    q0.push_back(rep(16'hC3C3));
    tick();
    in_valid0 = 1'b0;
    chk("comb_replace", out_data0, rep(16'hC3C3));
    chk("comb_replace_valid", {63'd0, out_valid0}, 64'd1);
    tick();
    chk("comb_empty", {63'd0, out_valid0}, 64'd0);

`ifdef PIPE_STAGE_STALL_CNT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready1 = 1'b0;
    in_valid1 = 1'b1; in_data1 = rep(16'h7777); q1.push_back(rep(16'h7777));
    tick();
    in_valid1 = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("stall_cnt_7", {32'd0, stall_cnt1}, 64'd7);
    flush1 = 1'b1; out_ready1 = 1'b1;
    tick();
    flush1 = 1'b0;
    chk("stall_cnt_after_flush", {32'd0, stall_cnt1}, 64'd7);
    chk("stall_flush_valid", {63'd0, out_valid1}, 64'd0);
`endif

    // Mid-stream reset squashes and zeroes, overriding an offered beat.
    out_ready1 = 1'b0;
    in_valid1 = 1'b1; in_data1 = rep(16'hEEEE);
    tick();
    in_data1 = rep(16'hF0F0); rst = 1'b1;
    tick();
    rst = 1'b0; in_valid1 = 1'b0;
    chk("midrst_valid", {63'd0, out_valid1}, 64'd0);
    chk("midrst_data", out_data1, 64'd0);
    chk("midrst_ready", {63'd0, in_ready1}, 64'd1);
`ifdef PIPE_STAGE_STALL_CNT_EN
    chk("stall_cnt_rst", {32'd0, stall_cnt1}, 64'd0);
`endif
    tick();
    chk("midrst_stays_empty", {63'd0, out_valid1}, 64'd0);
    out_ready1 = 1'b1;
    tick();

    chk("sb1_empty", 64'(q1.size()), 64'd0);
    chk("sb0_empty", 64'(q0.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
